// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline: merges stage stall requests,
// issues exception/ERET flushes (deferred while MEM is stalled), and tracks stall statistics.
module pipeline_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        exc_valid,
   input  logic        exc_eret,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles,
   output logic        stall_timeout
);

   localparam int unsigned STALL_W = 6;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned TMO_W   = 16;
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

   localparam logic [STALL_W-1:0] STALL_MEM = 6'b011111;
   localparam logic [STALL_W-1:0] STALL_EX  = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_ID  = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_IF  = 6'b000011;

   typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PC_W-1:0]    r_pend_pc;
   logic [PC_W-1:0]    w_pend_pc_nxt;
   logic [STALL_W-1:0] w_req_stall;
   logic [PC_W-1:0]    w_target;
   logic [31:0]        r_stall_cycles;
   logic [TMO_W-1:0]   r_tmo_cnt;
   logic [TMO_W-1:0]   w_tmo_inc;
   logic               r_stall_timeout;

   // Highest requesting stage wins.
   always_comb begin
      if (stallreq_mem)     w_req_stall = STALL_MEM;
      else if (stallreq_ex) w_req_stall = STALL_EX;
      else if (stallreq_id) w_req_stall = STALL_ID;
      else if (stallreq_if) w_req_stall = STALL_IF;
      else                  w_req_stall = '0;
   end

   assign w_target = exc_eret ? cp0_epc : EXC_VECTOR;

   always_comb begin
      w_state_nxt   = r_state;
      w_pend_pc_nxt = r_pend_pc;
      stall         = w_req_stall;
      flush         = 1'b0;
      new_pc        = '0;
      if (rst) begin
         stall         = '0;
         w_state_nxt   = RUN;
         w_pend_pc_nxt = '0;
      end else begin
         unique case (r_state)
            RUN: begin
               if (exc_valid) begin
                  if (stallreq_mem) begin
                     w_pend_pc_nxt = w_target;
                     w_state_nxt   = PEND;
                  end else begin
                     flush  = 1'b1;
                     stall  = '0;
                     new_pc = w_target;
                  end
               end
            end
            PEND: begin
               // MEM instruction is frozen, so new exception inputs are ignored here.
               if (stallreq_mem) begin
                  stall = STALL_MEM;
               end else begin
                  flush       = 1'b1;
                  stall       = '0;
                  new_pc      = r_pend_pc;
                  w_state_nxt = RUN;
               end
            end
            default: w_state_nxt = RUN;
         endcase
      end
   end

   assign w_tmo_inc = (r_tmo_cnt == TMO_LIMIT) ? r_tmo_cnt : r_tmo_cnt + TMO_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= RUN;
         r_pend_pc       <= '0;
         r_stall_cycles  <= '0;
         r_tmo_cnt       <= '0;
         r_stall_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pend_pc <= w_pend_pc_nxt;
         if (stall[0] && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (stall[0]) begin
            r_tmo_cnt <= w_tmo_inc;
            if (w_tmo_inc == TMO_LIMIT)
               r_stall_timeout <= 1'b1;
         end else begin
            r_tmo_cnt <= '0;
         end
      end
   end

   assign stall_cycles  = r_stall_cycles;
   assign stall_timeout = r_stall_timeout;

endmodule
